seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL provide parameter SCAN_DIV, default 50000, clock cycles per digit slot (>= 2).
REQ-003 SHALL provide parameter GUARD, default 2, anode-off cycles at the start of each slot (0..SCAN_DIV-1).
REQ-004 SHALL provide parameter SEG_ACT_LOW, default 1: segment and dp outputs are active-low when 1.
REQ-005 SHALL provide parameter AN_ACT_LOW, default 1: anode outputs are active-low when 1.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 din  in  4*DIGITS  hex nibbles; digit k = din[4k+3:4k], digit 0 rightmost.
REQ-009 dp_in  in  DIGITS  decimal point request per digit.
REQ-010 blank  in  DIGITS  force-blank per digit.
REQ-011 lzb  in  1  leading-zero blanking enable, sampled on load.
REQ-012 load  in  1  capture din/dp_in/blank/lzb into pending register.
REQ-013 seg  out  7  segments, seg[6]=a ... seg[0]=g, registered.
REQ-014 dp  out  1  decimal point, registered.
REQ-015 an  out  DIGITS  one-hot digit enable, registered.
REQ-016 pending  out  1  loaded data not yet committed to display.
REQ-017 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-018 Divider: counts 0..SCAN_DIV-1 and wraps; tick asserted in the cycle count = SCAN_DIV-1.
REQ-019 On tick, idx SHALL advance by 1, wrapping DIGITS-1 -> 0.
REQ-020 Frame boundary = tick with idx = DIGITS-1; frame_done SHALL be 1 in the following cycle only.
REQ-021 load=1 SHALL write the pending register and set pending=1; repeated loads overwrite it, last wins.
REQ-022 At a frame boundary with pending=1, pending contents SHALL be copied to the display register and pending cleared, in the same edge.
REQ-023 load coincident with a frame boundary: the pre-load pending value (if any) commits; the new value is held, and pending stays 1 until the next boundary.
REQ-024 Logical segment pattern (1 = lit, a..g), hex 0-F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
REQ-025 With lzb=1, digits from DIGITS-1 downward SHALL be blanked while their nibble is 0, stopping at the first nonzero digit; digit 0 is never lzb-blanked.
REQ-026 A digit blanked by blank[k] or lzb SHALL drive all segments and dp unlit; its anode is still asserted.
REQ-027 When count < GUARD, all anodes SHALL be inactive; otherwise an[idx] is active and all others inactive.
REQ-028 seg/dp/an SHALL be registered from idx, count and the display register, so they update one cycle after the change of idx/count.
REQ-029 Logical values SHALL be inverted at the outputs when the corresponding *_ACT_LOW parameter is 1.

Reset
REQ-030 rst=1 SHALL immediately clear count, idx, the display and pending registers, pending and frame_done.
REQ-031 During reset, all anodes, segments and dp SHALL be at their inactive levels (an, seg and dp all 1 with default parameters).
REQ-032 After release, the display SHALL show "0" on every digit, with anodes held off for GUARD+1 cycles after release.
REQ-033 Reset mid-frame SHALL discard pending data, and no frame_done is produced for the aborted frame.

Verification (DIGITS=4, SCAN_DIV=4, GUARD=1, active-low defaults)
REQ-034 Reset release, no load -> an cycles 1110,1101,1011,0111, each slot active 3 of 4 cycles with an=1111 in the guard cycle; seg=0000001 throughout; frame_done every 16 cycles.
REQ-035 load din=16'h1A2F, dp_in=4'b0100 mid-frame -> pending=1 until the next boundary; the following frame shows digit0 seg=0111000, digit1 seg=0010010, digit2 seg=0001000 with dp=0, digit3 seg=1001111.
REQ-036 load din=16'h0050, lzb=1 -> digits 3 and 2 all segments off (1111111) with anodes still cycling; digit1 seg=0100100; digit0 seg=0000001.
REQ-037 load on the boundary cycle with pending already set -> the older value displays this frame, the newer value displays next frame, and pending=1 across the boundary.
REQ-038 rst pulse mid-slot with pending=1 -> outputs go inactive asynchronously; after release, all digits show 0 and pending=0.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 7-seg driver; load latches din/dp_in/blank/lzb as pending, committed at frame boundary to seg/dp/an, frame_done pulses per frame
module seg7_scan #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] G = CW'(GUARD);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
  localparam logic SL = (SEG_ACT_LOW != 0);
  localparam logic AL = (AN_ACT_LOW != 0);
  localparam logic [6:0] LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] p_din, d_din;
  logic [DIGITS-1:0] p_dp, p_bl, d_dp, d_bl, lzm, oh;
  logic p_lzb, d_lzb, tick, frame, z, off, sel_dp;
  logic [3:0] nib;
  logic [6:0] seg_l;
  logic [DIGITS-1:0] an_l;
  assign tick = count == LAST;
  assign frame = tick && idx == ILAST;
  always_comb begin
    nib = '0;
    sel_dp = 1'b0;
    oh = '0;
    lzm = '0;
    z = d_lzb;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z = z & (d_din[4*k +: 4] == 4'h0);
      lzm[k] = z;
    end
    off = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      oh[k] = idx == IW'(k);
      nib = oh[k] ? d_din[4*k +: 4] : nib;
      sel_dp = oh[k] ? d_dp[k] : sel_dp;
      off = oh[k] ? (d_bl[k] | lzm[k]) : off;
    end
    seg_l = off ? 7'h00 : LUT[nib];
    an_l = count < G ? '0 : oh;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      idx <= '0;
      frame_done <= 1'b0;
      pending <= 1'b0;
      {p_din, p_dp, p_bl, p_lzb} <= '0;
      {d_din, d_dp, d_bl, d_lzb} <= '0;
      seg <= {7{SL}};
      dp <= SL;
      an <= {DIGITS{AL}};
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) idx <= idx == ILAST ? '0 : idx + 1'b1;
      frame_done <= frame;
      if (frame && pending) {d_din, d_dp, d_bl, d_lzb} <= {p_din, p_dp, p_bl, p_lzb};
      if (load) {p_din, p_dp, p_bl, p_lzb} <= {din, dp_in, blank, lzb};
      pending <= load | (pending & ~frame);
      seg <= seg_l ^ {7{SL}};
      dp <= (sel_dp & ~off) ^ SL;
      an <= an_l ^ {DIGITS{AL}};
    end
endmodule
